// File: rtl/div_seq_pkg.sv
// Shared types and sizing for the iterative HI/LO divider.
package div_seq_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX} div_state_t;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step: shift in next dividend bit, trial-subtract, select.
module div_seq_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] trial;

    // Full WIDTH+1-bit partial remainder so large unsigned divisors never lose the top bit.
    assign trial = {r_in, q_in[WIDTH-1]} - {1'b0, b};

    always_comb begin
        r_out = {r_in[WIDTH-2:0], q_in[WIDTH-1]};
        q_out = {q_in[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_out = trial[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/negate.sv
// Two's-complement negation, shared by operand abs and result sign fix-up.
module negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = ~x + WIDTH'(1);

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: LO = quotient, HI = remainder.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SIGN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_neg, b_neg, q_neg, r_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_r, step_q;

    negate #(.WIDTH(WIDTH)) u_neg_a (.x(A),   .y(a_neg));
    negate #(.WIDTH(WIDTH)) u_neg_b (.x(B),   .y(b_neg));
    negate #(.WIDTH(WIDTH)) u_neg_q (.x(q_q), .y(q_neg));
    negate #(.WIDTH(WIDTH)) u_neg_r (.x(r_q), .y(r_neg));

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .b     (b_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    assign a_abs = (SIGN && A[WIDTH-1]) ? a_neg : A;
    assign b_abs = (SIGN && B[WIDTH-1]) ? b_neg : B;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        a_raw_d = a_raw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (START) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                    r_d     = '0;
                    q_d     = a_abs;
                    b_d     = b_abs;
                    a_raw_d = A;
                    qneg_d  = SIGN & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d  = SIGN & A[WIDTH-1];
                    dz_d    = (B == '0);
                end
            end
            DIV_RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                lo_d    = dz_q ? '1      : (qneg_q ? q_neg : q_q);
                hi_d    = dz_q ? a_raw_q : (rneg_q ? r_neg : r_q);
                done_d  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            a_raw_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            a_raw_q <= a_raw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = (state_q == DIV_RUN) || (state_q == DIV_FIX);
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against a scoreboard of expected HI/LO pairs.
module tb_div_seq;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        SIGN;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];

    div_seq #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .SIGN  (SIGN),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder follows dividend, MIPS div-by-zero result.
    function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int   sa;
        int   sbv;
        sa  = a;
        sbv = b;
        if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else if (!s) begin
            r.lo = a / b;
            r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000;
            r.hi = 32'd0;
        end else begin
            r.lo = sa / sbv;
            r.hi = sa % sbv;
        end
        return r;
    endfunction

    // Called just after an edge; the following edge samples START.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        res_t e;
        e.hi = exp_hi;
        e.lo = exp_lo;
        sb.push_back(e);
        START = 1'b1;
        SIGN  = s;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Waits for DONE, checks latency, BUSY profile and the popped scoreboard entry.
    task automatic wait_done(input int exp_lat, input string tag);
        int   k;
        bit   seen;
        bit   busy_ok;
        res_t e;
        seen    = 1'b0;
        busy_ok = 1'b1;
        k       = 0;
        for (int i = 1; i <= exp_lat + 8; i++) begin
            @(posedge CLK);
            #1;
            k = i;
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            if (!BUSY) busy_ok = 1'b0;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_lo"}, LO, e.lo);
            check({tag, "_hi"}, HI, e.hi);
        end else begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end
    endtask

    task automatic done_drops(input string tag);
        @(posedge CLK);
        #1;
        check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        res_t r;
        bit   seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        RESET = 1'b1;
        START = 1'b0;
        SIGN  = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        start_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        check("divu100_busy_edge0", 32'(BUSY), 32'd1);
        wait_done(33, "divu100_7");
        done_drops("divu100_7");

        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done(33, "div_m7_2");
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        wait_done(33, "div_7_m2");
        start_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
        wait_done(33, "divu_max_1");
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        wait_done(33, "div_ovf");
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1);
        wait_done(33, "divu_big_div");
        start_op(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        wait_done(33, "divu_5_0");
        start_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        wait_done(33, "div_m5_0");
        done_drops("div_m5_0");

        // START while busy with fresh operands must be ignored.
        start_op(1'b0, 32'd1000, 32'd33, 32'd10, 32'd30);
        repeat (9) begin
            @(posedge CLK);
            #1;
        end
        START = 1'b1;
        SIGN  = 1'b1;
        A     = 32'h1234_5678;
        B     = 32'd3;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(23, "busy_start_ignored");

        // START in the DONE cycle is accepted; HI/LO hold until the next completion.
        start_op(1'b1, 32'hFFFF_FF9C, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFF5);
        check("done_cycle_hold_lo", LO, 32'd30);
        check("done_cycle_hold_hi", HI, 32'd10);
        wait_done(33, "done_cycle_start");
        done_drops("done_cycle_start");

        // Asynchronous reset mid-run aborts the op.
        start_op(1'b0, 32'd77, 32'd5, 32'd2, 32'd15);
        repeat (14) begin
            @(posedge CLK);
            #1;
        end
        #3;
        RESET = 1'b1;
        #1;
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        check("midrst_done", 32'(DONE), 32'd0);
        void'(sb.pop_back());
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        start_op(1'b0, 32'd77, 32'd5, 32'd2, 32'd15);
        wait_done(33, "after_rst");

        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = (n < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            r  = model(rs, ra, rb);
            start_op(rs, ra, rb, r.hi, r.lo);
            wait_done(33, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
